// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
// Shared types and default constants for the frequency meter gate sequencer.
//   gate_state_t    : measurement sequencer states
//   DEF_CNT_W       : default edge-counter / result width
//   DEF_SETTLE_CYCLES: default drain delay between gate close and latch
//   max2()          : elaboration-time helper used to size the shared timer
// -----------------------------------------------------------------------------
package freq_meter_pkg;

   localparam int DEF_CNT_W         = 32;
   localparam int DEF_SETTLE_CYCLES = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      GATE   = 3'd2,
      SETTLE = 3'd3,
      LATCH  = 3'd4
   } gate_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// -----------------------------------------------------------------------------
// gate_timer
// Loadable down-counter shared by the gate and settle phases.
//   clk      : system clock
//   rst      : synchronous reset, active-low
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; holds at zero
//   zero     : count is zero
// -----------------------------------------------------------------------------
module gate_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst)                      cnt <= '0;
      else if (load)                 cnt <= load_val;
      else if (dec && cnt != '0)     cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl
// Measurement sequencer for the edge counter: clear, gate for GATE_CYCLES,
// settle for SETTLE_CYCLES while the counter input pipeline drains, latch.
//   clk          : system clock
//   rst          : synchronous reset, active-low
//   start        : request a measurement (sampled only in IDLE)
//   stop         : abort measurement / leave continuous mode
//   cont         : continuous mode, sampled in LATCH
//   counter      : live count from the edge counter
//   cnt_enable   : counter enable (gate window)
//   cnt_clear    : counter synchronous clear
//   result       : last latched count
//   result_valid : one-cycle pulse when result updates
//   busy         : sequencer not IDLE
//   overflow     : counter wrapped during the last window
// Optional build macro FREQ_GATE_CTRL_OVF_EN enables wrap detection; without
// it overflow is tied low.
// -----------------------------------------------------------------------------
module freq_gate_ctrl
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES   = 100_000_000,
   parameter int SETTLE_CYCLES = freq_meter_pkg::DEF_SETTLE_CYCLES,
   parameter int CNT_W         = freq_meter_pkg::DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cont,
   input  logic [CNT_W-1:0] counter,
   output logic             cnt_enable,
   output logic             cnt_clear,
   output logic [CNT_W-1:0] result,
   output logic             result_valid,
   output logic             busy,
   output logic             overflow
);

   localparam int TMR_W = $clog2(max2(GATE_CYCLES, SETTLE_CYCLES) + 1);

   gate_state_t      state, state_nxt;
   logic             tmr_load, tmr_dec, tmr_zero;
   logic [TMR_W-1:0] tmr_val;

   gate_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Timer is loaded on the cycle before each timed phase begins, so the
   // zero flag lands on the last cycle of that phase.
   always_comb begin
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      tmr_val  = TMR_W'(GATE_CYCLES - 1);
      case (state)
         CLEAR:  tmr_load = 1'b1;
         GATE: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(SETTLE_CYCLES - 1);
            end else begin
               tmr_dec = 1'b1;
            end
         end
         SETTLE: tmr_dec = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !stop) state_nxt = CLEAR;
         CLEAR:   state_nxt = stop ? IDLE : GATE;
         GATE:    if (stop) state_nxt = IDLE;
                  else if (tmr_zero) state_nxt = SETTLE;
         SETTLE:  if (stop) state_nxt = IDLE;
                  else if (tmr_zero) state_nxt = LATCH;
         LATCH:   state_nxt = (cont && !stop) ? CLEAR : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   assign cnt_enable = (state == GATE);
   assign cnt_clear  = (state == CLEAR);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= (state == LATCH);
         if (state == LATCH) result <= counter;
      end
   end

`ifdef FREQ_GATE_CTRL_OVF_EN
   logic [CNT_W-1:0] prev_count;
   logic             ovf_flag;

   // prev_count is zeroed in CLEAR so the stale count from the previous
   // window cannot look like a wrap on the first gate cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prev_count <= '0;
         ovf_flag   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               prev_count <= '0;
               ovf_flag   <= 1'b0;
            end
            GATE, SETTLE: begin
               prev_count <= counter;
               if (counter < prev_count) ovf_flag <= 1'b1;
            end
            LATCH: overflow <= ovf_flag;
            default: ;
         endcase
      end
   end
`else
   assign overflow = 1'b0;
`endif

endmodule
